logger_fifo_frame: RTL and testbench

Parametrised, frame-aware synchronous FIFO. It is the successor to the byte-wide logger FIFO. It generalises data width, depth and read mode, and adds frame commit/rollback. Beats become readable only once their frame's last beat is written. A frame that overflows or is aborted is discarded in full, so the downstream UDP packetiser never sees a partial log record.

---
 rtl/logger_fifo_pkg.sv | 16 +
 rtl/logger_fifo_ram.sv | 46 ++++
 rtl/logger_fifo_frame.sv | 186 ++++++++++++++++++
 tb/tb_logger_fifo_frame.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logger_fifo_pkg.sv
// Shared types and sizing helpers for the frame-aware logger FIFO.
package logger_fifo_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_e;

    localparam int unsigned DROP_CNT_W = 16;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/logger_fifo_ram.sv
// Simple dual-port storage for the logger FIFO; ASYNC_RD selects an async (FWFT) or registered read port.
module logger_fifo_ram #(
    parameter int unsigned DW       = 9,
    parameter int unsigned DEPTH    = 256,
    parameter bit          ASYNC_RD = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          peek_msb
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Flag bit of the word at the read address, needed before a registered read completes.
    assign peek_msb = mem[raddr][DW-1];

    generate
        if (ASYNC_RD) begin : g_async
            logic unused_rd;
            assign unused_rd = ^{re, rst};
            assign rdata     = mem[raddr];
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/logger_fifo_frame.sv
// Frame-aware synchronous FIFO with commit/rollback; beats become readable only after the frame's last beat.
// Optional statistics (drop_count, high_water) are built when LOGGER_FIFO_STATS_EN is defined.
module logger_fifo_frame
    import logger_fifo_pkg::*;
#(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned DEPTH            = 256,
    parameter int unsigned PROG_FULL_THRESH = DEPTH - 56,
    parameter int unsigned FWFT             = 1,
    localparam int unsigned PW              = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_last,
    input  logic                  wr_abort,
    output logic                  full,
    output logic                  prog_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_last,
    output logic                  dout_valid,
    output logic                  empty,
    output logic [PW-1:0]         frames_avail,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [PW-1:0]         high_water
);

    localparam int unsigned AW = PW - 1;

    wr_state_e       state, state_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]   cm_ptr, cm_ptr_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   used_wr;
    logic [PW-1:0]   frames_q;
    logic            we, commit, ovf_nxt, ovf_q;
    logic            rd_acc, rd_last;
    logic [WIDTH:0]  rdata;

    assign used_wr   = wr_ptr - rd_ptr;
    assign full      = (used_wr == PW'(DEPTH));
    assign prog_full = (used_wr >= PW'(PROG_FULL_THRESH));
    assign empty     = (cm_ptr == rd_ptr);
    assign rd_acc    = rd_en && !empty;

    // Write-side state machine: accept, commit, roll back on overflow or abort.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        cm_ptr_nxt = cm_ptr;
        we         = 1'b0;
        commit     = 1'b0;
        ovf_nxt    = 1'b0;
        if (wr_abort) begin
            wr_ptr_nxt = cm_ptr;
            state_nxt  = ACCEPT;
        end else begin
            case (state)
                ACCEPT: begin
                    if (wr_en) begin
                        if (full) begin
                            wr_ptr_nxt = cm_ptr;
                            ovf_nxt    = 1'b1;
                            if (!wr_last) begin
                                state_nxt = DROP;
                            end
                        end else begin
                            we         = 1'b1;
                            wr_ptr_nxt = wr_ptr + PW'(1);
                            if (wr_last) begin
                                cm_ptr_nxt = wr_ptr + PW'(1);
                                commit     = 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (wr_en && wr_last) begin
                        state_nxt = ACCEPT;
                    end
                end
                default: state_nxt = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            rd_ptr   <= '0;
            frames_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            cm_ptr <= cm_ptr_nxt;
            ovf_q  <= ovf_nxt;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A commit and a last-beat read in the same cycle cancel out.
            case ({commit, rd_acc && rd_last})
                2'b10:   frames_q <= frames_q + PW'(1);
                2'b01:   frames_q <= frames_q - PW'(1);
                default: frames_q <= frames_q;
            endcase
        end
    end

    assign overflow     = ovf_q;
    assign frames_avail = frames_q;

    logger_fifo_ram #(
        .DW       (WIDTH + 1),
        .DEPTH    (DEPTH),
        .ASYNC_RD (FWFT != 0)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (wr_ptr[AW-1:0]),
        .wdata    ({wr_last, din}),
        .re       (rd_acc),
        .raddr    (rd_ptr[AW-1:0]),
        .rdata    (rdata),
        .peek_msb (rd_last)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout       = empty ? '0 : rdata[WIDTH-1:0];
            assign dout_last  = !empty && rdata[WIDTH];
            assign dout_valid = !empty;
        end else begin : g_std
            logic dv_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dv_q <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                end
            end
            assign dout       = rdata[WIDTH-1:0];
            assign dout_last  = rdata[WIDTH];
            assign dout_valid = dv_q;
        end
    endgenerate

`ifdef LOGGER_FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] drop_q;
    logic [PW-1:0]         hw_q;

    // Saturating drop counter and peak speculative occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
            hw_q   <= '0;
        end else begin
            if (ovf_nxt && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_CNT_W'(1);
            end
            if (used_wr > hw_q) begin
                hw_q <= used_wr;
            end
        end
    end

    assign drop_count = drop_q;
    assign high_water = hw_q;
`else
    assign drop_count = '0;
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_logger_fifo_frame.sv
// Bench for logger_fifo_frame: FWFT and standard instances share stimulus and are checked against a queue model.
module tb_logger_fifo_frame;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PFT   = 10;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;
`ifdef LOGGER_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, wr_en, wr_last, wr_abort, rd_en;
    logic [WIDTH-1:0] din;

    logic             full_f, prog_full_f, overflow_f, dout_last_f, dout_valid_f, empty_f;
    logic [WIDTH-1:0] dout_f;
    logic [PW-1:0]    frames_f, hw_f;
    logic [15:0]      drop_f;
    logic             full_s, prog_full_s, overflow_s, dout_last_s, dout_valid_s, empty_s;
    logic [WIDTH-1:0] dout_s;
    logic [PW-1:0]    frames_s, hw_s;
    logic [15:0]      drop_s;

    always #5 clk = ~clk;

    logger_fifo_frame #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PROG_FULL_THRESH(PFT), .FWFT(1)) u_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .wr_last(wr_last), .wr_abort(wr_abort),
        .full(full_f), .prog_full(prog_full_f), .overflow(overflow_f), .rd_en(rd_en),
        .dout(dout_f), .dout_last(dout_last_f), .dout_valid(dout_valid_f), .empty(empty_f),
        .frames_avail(frames_f), .drop_count(drop_f), .high_water(hw_f)
    );

    logger_fifo_frame #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PROG_FULL_THRESH(PFT), .FWFT(0)) u_s (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .wr_last(wr_last), .wr_abort(wr_abort),
        .full(full_s), .prog_full(prog_full_s), .overflow(overflow_s), .rd_en(rd_en),
        .dout(dout_s), .dout_last(dout_last_s), .dout_valid(dout_valid_s), .empty(empty_s),
        .frames_avail(frames_s), .drop_count(drop_s), .high_water(hw_s)
    );

    // ---------------- reference model: committed / pending beat queues ----------------
    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t com_q[$];
    beat_t pend_q[$];
    bit    dropping;
    int    drops;
    int    hw;
    bit    ovf_exp;
    beat_t std_exp;
    bit    std_dv;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int frames_of();
        int n = 0;
        foreach (com_q[i]) if (com_q[i].last) n++;
        return n;
    endfunction

    function automatic int used_of();
        return com_q.size() + pend_q.size();
    endfunction

    task automatic model_reset();
        com_q.delete();
        pend_q.delete();
        dropping = 1'b0;
        drops    = 0;
        hw       = 0;
        ovf_exp  = 1'b0;
        std_exp  = '0;
        std_dv   = 1'b0;
    endtask

    task automatic model_step();
        int    used;
        bit    full_m;
        beat_t b;
        used   = used_of();
        full_m = (used == DEPTH);
        if (used > hw) hw = used;
        ovf_exp = 1'b0;
        std_dv  = 1'b0;
        if (rd_en && com_q.size() != 0) begin
            b       = com_q.pop_front();
            std_exp = b;
            std_dv  = 1'b1;
        end
        if (wr_abort) begin
            pend_q.delete();
            dropping = 1'b0;
        end else if (dropping) begin
            if (wr_en && wr_last) dropping = 1'b0;
        end else if (wr_en) begin
            if (full_m) begin
                pend_q.delete();
                ovf_exp = 1'b1;
                if (drops < 65535) drops++;
                if (!wr_last) dropping = 1'b1;
            end else begin
                pend_q.push_back({wr_last, din});
                if (wr_last) begin
                    foreach (pend_q[i]) com_q.push_back(pend_q[i]);
                    pend_q.delete();
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int used;
        used = used_of();
        chk("empty_f",  64'(empty_f),  64'(com_q.size() == 0));
        chk("empty_s",  64'(empty_s),  64'(com_q.size() == 0));
        chk("full_f",   64'(full_f),   64'(used == DEPTH));
        chk("full_s",   64'(full_s),   64'(used == DEPTH));
        chk("pfull_f",  64'(prog_full_f), 64'(used >= PFT));
        chk("pfull_s",  64'(prog_full_s), 64'(used >= PFT));
        chk("frames_f", 64'(frames_f), 64'(frames_of()));
        chk("frames_s", 64'(frames_s), 64'(frames_of()));
        chk("ovf_f",    64'(overflow_f), 64'(ovf_exp));
        chk("ovf_s",    64'(overflow_s), 64'(ovf_exp));
        chk("dv_f",     64'(dout_valid_f), 64'(com_q.size() != 0));
        if (com_q.size() != 0)
            chk("dout_f", 64'({dout_last_f, dout_f}), 64'(com_q[0]));
        chk("dv_s",     64'(dout_valid_s), 64'(std_dv));
        chk("dout_s",   64'({dout_last_s, dout_s}), 64'(std_exp));
        chk("drop_f",   64'(drop_f), STATS ? 64'(drops) : 64'd0);
        chk("drop_s",   64'(drop_s), STATS ? 64'(drops) : 64'd0);
        chk("hw_f",     64'(hw_f),   STATS ? 64'(hw) : 64'd0);
        chk("hw_s",     64'(hw_s),   STATS ? 64'(hw) : 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic we, input logic [WIDTH-1:0] d, input logic last,
                         input logic ab, input logic re);
        wr_en    = we;
        din      = d;
        wr_last  = last;
        wr_abort = ab;
        rd_en    = re;
        tick();
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic             we;
        logic [WIDTH-1:0] d;
        logic             last;
        logic             ab;
        logic             re;
        logic             e_empty;
        int               e_frames;
        logic             e_ovf;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [WIDTH-1:0] d, input logic last,
                                input logic ab, input logic re, input logic e_empty,
                                input int e_frames, input logic e_ovf);
        vec_t v;
        v.we = we; v.d = d; v.last = last; v.ab = ab; v.re = re;
        v.e_empty = e_empty; v.e_frames = e_frames; v.e_ovf = e_ovf;
        return v;
    endfunction

    vec_t tv[16];

    initial begin
        // frame A0..A3, then drain
        tv[0]  = mk(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[1]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[2]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[3]  = mk(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tv[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        tv[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        tv[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        tv[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        // three beats, abort (with a discarded same-cycle beat), then 55,66
        tv[8]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[9]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[10] = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[11] = mk(1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        tv[12] = mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        tv[13] = mk(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tv[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        tv[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);

        rst = 1'b1; wr_en = 1'b0; din = '0; wr_last = 1'b0; wr_abort = 1'b0; rd_en = 1'b0;
        tick();
        chk("rst_dout_f", 64'({dout_last_f, dout_f}), 64'd0);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].we, tv[i].d, tv[i].last, tv[i].ab, tv[i].re);
            chk($sformatf("vec%0d_empty", i), 64'(empty_f), 64'(tv[i].e_empty));
            chk($sformatf("vec%0d_frames", i), 64'(frames_f), 64'(tv[i].e_frames));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow_f), 64'(tv[i].e_ovf));
            if (i == 4)  chk("vec_A0", 64'({dout_last_s, dout_s}), 64'h0A0);
            if (i == 7)  chk("vec_A3", 64'({dout_last_s, dout_s}), 64'h1A3);
            if (i == 13) chk("vec_55", 64'({dout_last_f, dout_f}), 64'h055);
        end
        chk("t2_drop", 64'(drop_f), 64'd0);

        // overflow of a second frame behind a committed 12-beat frame
        for (int i = 0; i < 12; i++) drive(1'b1, WIDTH'(8'h30 + i), i == 11, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, WIDTH'(8'h40 + i), i == 5, 1'b0, 1'b0);
            if (i == 3) chk("t3_full_b4", 64'(full_f), 64'd1);
            if (i == 4) chk("t3_ovf", 64'(overflow_f), 64'd1);
        end
        chk("t3_ovf_once", 64'(overflow_f), 64'd0);
        chk("t3_frames",   64'(frames_f), 64'd1);
        chk("t3_notfull",  64'(full_f), 64'd0);
        chk("t3_pfull",    64'(prog_full_f), 64'd1);
        chk("t3_drop",     64'(drop_f), STATS ? 64'd1 : 64'd0);
        for (int i = 0; i < 12; i++) rd();
        chk("t3_drained",  64'(empty_f), 64'd1);

        // standard-mode read latency
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        rd();
        chk("t4_dv1",   64'(dout_valid_s), 64'd1);
        chk("t4_d11",   64'({dout_last_s, dout_s}), 64'h011);
        idle();
        chk("t4_dv0",   64'(dout_valid_s), 64'd0);
        chk("t4_hold",  64'(dout_s), 64'h11);
        rd();
        chk("t4_d22",   64'({dout_valid_s, dout_last_s, dout_s}), 64'h322);
        idle();
        rd();
        chk("t4_empty_rd", 64'(dout_valid_s), 64'd0);

        // fill to 16, then read and write together at full
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, WIDTH'(8'h80 + i), i == 15, 1'b0, 1'b0);
            if (i == 8) chk("t5_pfull9", 64'(prog_full_f), 64'd0);
            if (i == 9) chk("t5_pfull10", 64'(prog_full_f), 64'd1);
        end
        chk("t5_full", 64'(full_f), 64'd1);
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("t5_ovf",     64'(overflow_f), 64'd1);
        chk("t5_unfull",  64'(full_f), 64'd0);
        chk("t5_rd_s",    64'({dout_valid_s, dout_last_s, dout_s}), 64'h280);
        drive(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);
        chk("t5_frames",  64'(frames_f), 64'd1);
        for (int i = 0; i < 15; i++) rd();
        chk("t5_drained", 64'(frames_f), 64'd0);

        // reset mid-frame with two committed frames stored
        drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_frames", 64'(frames_f), 64'd2);
        rst = 1'b1;
        drive(1'b1, 8'hC5, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t6_empty",  64'(empty_f), 64'd1);
        chk("t6_frames", 64'(frames_f), 64'd0);
        chk("t6_flags",  64'({full_f, prog_full_f, overflow_f}), 64'd0);
        chk("t6_stats",  64'({drop_f, hw_f}), 64'd0);

        // randomized traffic against the model
        for (int ph = 0; ph < 12; ph++) begin
            int rd_pct, last_pct;
            rd_pct   = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 35 : 80);
            last_pct = (ph % 4 == 3) ? 2 : 20;
            for (int c = 0; c < 200; c++) begin
                drive(($urandom % 100) < 60, WIDTH'($urandom),
                      ($urandom % 100) < last_pct, ($urandom % 100) < 3,
                      ($urandom % 100) < rd_pct);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
